// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets N_SRC byte producers share one UART byte
//   channel. A granted source keeps the channel (line locking) until it sends
//   EOL_CHAR, has sent MAX_BURST bytes, or leaves its valid low for
//   IDLE_TIMEOUT cycles. This keeps console lines from interleaving. A single
//   output register sits between the arbiter and the UART.
// Ports
//   clock, reset_n      clock (rising edge) and async active-low reset
//   src_valid/ready     per-source handshake, one bit per source
//   src_bits            source i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   serial_out_*        registered byte channel towards the UART
//   grant_idx           currently locked source
//   busy                high while a source holds the lock
module uart_tx_arbiter #(
  parameter int                    N_SRC        = 4,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    MAX_BURST    = 64,
  parameter logic [DATA_WIDTH-1:0] EOL_CHAR     = 8'h0A,
  parameter int                    IDLE_TIMEOUT = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [N_SRC-1:0]            src_valid,
  output logic [N_SRC-1:0]            src_ready,
  input  logic [N_SRC*DATA_WIDTH-1:0] src_bits,
  output logic                        serial_out_valid,
  input  logic                        serial_out_ready,
  output logic [DATA_WIDTH-1:0]       serial_out_bits,
  output logic [$clog2(N_SRC)-1:0]    grant_idx,
  output logic                        busy
);

  localparam int GW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  logic [GW-1:0]         r_grant;
  logic [GW-1:0]         r_rr_ptr;
  logic [CW-1:0]         r_count;
  logic [IW-1:0]         r_idle;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_bits;

  logic                  w_slot_free;
  logic                  w_g_valid;
  logic [DATA_WIDTH-1:0] w_g_bits;
  logic                  w_accept;
  logic                  w_found;
  logic [GW-1:0]         w_pick;
  logic [GW:0]           w_sum;
  logic [GW-1:0]         w_rr_next;
  logic [CW-1:0]         w_count_inc;
  logic [IW-1:0]         w_idle_inc;
  logic                  w_burst_end;
  logic                  w_idle_end;
  logic                  w_eol;

  assign w_slot_free = !r_out_valid || serial_out_ready;
  assign w_g_valid   = src_valid[r_grant];
  assign w_accept    = (r_state == S_LOCKED) && w_g_valid && w_slot_free;
  assign w_count_inc = r_count + CW'(1);
  assign w_idle_inc  = r_idle + IW'(1);
  assign w_burst_end = (w_count_inc == CW'(MAX_BURST));
  assign w_idle_end  = (w_idle_inc == IW'(IDLE_TIMEOUT));
  assign w_eol       = (w_g_bits == EOL_CHAR);
  // Explicit wrap so non-power-of-two source counts still rotate correctly.
  assign w_rr_next   = (r_grant == GW'(N_SRC - 1)) ? '0 : r_grant + GW'(1);

  // Byte mux for the granted source.
  always_comb begin
    w_g_bits = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_grant == GW'(i)) begin
        w_g_bits = src_bits[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_g_bits = w_g_bits;
      end
    end
  end

  // Round-robin pick: first valid source at or after r_rr_ptr, wrapping.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (w_sum >= (GW+1)'(N_SRC)) begin
        w_sum = w_sum - (GW+1)'(N_SRC);
      end else begin
        w_sum = w_sum;
      end
      if (!w_found && src_valid[w_sum[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[GW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Only the locked source sees ready, and only when the output slot frees.
  always_comb begin
    src_ready = '0;
    if ((r_state == S_LOCKED) && w_slot_free) begin
      src_ready[r_grant] = 1'b1;
    end else begin
      src_ready = '0;
    end
  end

  // Arbitration FSM, burst/idle counters and output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_count     <= '0;
      r_idle      <= '0;
      r_out_valid <= 1'b0;
      r_out_bits  <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_bits  <= w_g_bits;
      end else if (serial_out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end

      case (r_state)
        S_IDLE: begin
          r_count <= '0;
          r_idle  <= '0;
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= S_LOCKED;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOCKED: begin
          if (w_accept) begin
            // EOL and a full burst on the same byte collapse into one release.
            if (w_eol || w_burst_end) begin
              r_state  <= S_IDLE;
              r_rr_ptr <= w_rr_next;
              r_count  <= '0;
              r_idle   <= '0;
            end else begin
              r_count <= w_count_inc;
              r_idle  <= '0;
            end
          end else if (!w_g_valid) begin
            if (w_idle_end) begin
              r_state  <= S_IDLE;
              r_rr_ptr <= w_rr_next;
              r_count  <= '0;
              r_idle   <= '0;
            end else begin
              r_idle <= w_idle_inc;
            end
          end else begin
            // Valid but stalled by the UART: hold the idle count.
            r_idle <= r_idle;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign serial_out_valid = r_out_valid;
  assign serial_out_bits  = r_out_bits;
  assign grant_idx        = r_grant;
  assign busy             = (r_state == S_LOCKED);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios with exact
// timing plus a randomized phase checked against a rule-level model
// (byte scoreboard, release reasons, round-robin choice).
module tb_uart_tx_arbiter;
  localparam int N       = 4;
  localparam int W       = 8;
  localparam int MAXB    = 64;
  localparam int IDLE_TO = 16;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_ready;
  logic [N*W-1:0] src_bits;
  logic           serial_out_valid;
  logic           serial_out_ready;
  logic [W-1:0]   serial_out_bits;
  logic [1:0]     grant_idx;
  logic           busy;

  uart_tx_arbiter #(
    .N_SRC(N), .DATA_WIDTH(W), .MAX_BURST(MAXB), .EOL_CHAR(8'h0A), .IDLE_TIMEOUT(IDLE_TO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_bits(src_bits),
    .serial_out_valid(serial_out_valid), .serial_out_ready(serial_out_ready),
    .serial_out_bits(serial_out_bits), .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q [N][$];
  logic [7:0] exp_out[$];
  logic [7:0] out_log[$];
  int         seg_len_log[$];
  int         seg_src_log[$];
  bit         en [N];
  bit         rdy;
  int         acc_src, cyc, seg_len, idle_run, m_rr;
  bit         prev_busy, prev_rel, prev_stall, prev_acc;
  int         prev_grant, prev_idle;
  logic [N-1:0] prev_valid;
  logic [7:0] prev_bits, prev_acc_byte;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int rr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return 0;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic load(input int s, input string str);
    for (int i = 0; i < str.len(); i++) q[s].push_back(str[i]);
  endtask

  task automatic check_log(input string tag, input string str);
    check({tag, "_len"}, 32'(out_log.size()), 32'(str.len()));
    for (int i = 0; i < str.len() && i < out_log.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(out_log[i]), 32'(str[i]));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    src_valid = '0;
    src_bits = '0;
    serial_out_ready = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      en[i] = 1'b1;
    end
    exp_out.delete(); out_log.delete(); seg_len_log.delete(); seg_src_log.delete();
    acc_src = -1; cyc = 0; seg_len = 0; idle_run = 0; m_rr = 0;
    prev_busy = 1'b0; prev_rel = 1'b0; prev_stall = 1'b0; prev_acc = 1'b0;
    prev_grant = 0; prev_idle = 0; prev_valid = '0; prev_bits = '0; prev_acc_byte = '0;
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Observe one cycle (inputs already settled for the coming rising edge).
  task automatic sample();
    logic [7:0] b;
    cyc++;
    check("one_ready", 32'($countones(src_ready) <= 1), 32'd1);
    check("ready_grant_only", 32'(src_ready & ~(busy ? (4'b0001 << grant_idx) : 4'b0000)), 32'd0);
    // Lock / release rules
    if (prev_busy) begin
      check("release_rule", 32'(busy), 32'(!(prev_rel || prev_idle >= IDLE_TO)));
      if (busy) begin
        check("grant_held", 32'(grant_idx), 32'(prev_grant));
      end else begin
        seg_len_log.push_back(seg_len);
        seg_src_log.push_back(prev_grant);
        m_rr = (prev_grant + 1) % N;
      end
    end else begin
      check("arb_lock", 32'(busy), 32'(prev_valid != '0));
      if (busy) begin
        check("rr_pick", 32'(grant_idx), 32'(rr_pick(m_rr, prev_valid)));
        seg_len = 0;
        idle_run = 0;
      end
    end
    // Output register behaviour
    if (prev_stall) begin
      check("stall_valid", 32'(serial_out_valid), 32'd1);
      check("stall_bits", 32'(serial_out_bits), 32'(prev_bits));
    end
    if (prev_acc) begin
      check("lat_valid", 32'(serial_out_valid), 32'd1);
      check("lat_bits", 32'(serial_out_bits), 32'(prev_acc_byte));
    end
    if (serial_out_valid && serial_out_ready) begin
      if (exp_out.size() == 0) begin
        check("dup_byte", 32'(serial_out_bits), 32'hFFFF_FFFF);
      end else begin
        b = exp_out.pop_front();
        check("out_order", 32'(serial_out_bits), 32'(b));
      end
      out_log.push_back(serial_out_bits);
    end
    prev_stall = serial_out_valid && !serial_out_ready;
    prev_bits = serial_out_bits;
    // Accepts this cycle
    acc_src = -1;
    prev_rel = 1'b0;
    prev_acc = 1'b0;
    for (int i = 0; i < N; i++) if (src_valid[i] && src_ready[i]) acc_src = i;
    if (acc_src >= 0) begin
      b = q[acc_src][0];
      exp_out.push_back(b);
      seg_len++;
      idle_run = 0;
      prev_rel = (b == 8'h0A) || (seg_len == MAXB);
      prev_acc = 1'b1;
      prev_acc_byte = b;
    end else if (busy && !src_valid[grant_idx]) begin
      idle_run++;
    end
    prev_idle = idle_run;
    prev_busy = busy;
    prev_grant = int'(grant_idx);
    prev_valid = src_valid;
  endtask

  task automatic cycle();
    @(negedge clock);
    if (acc_src >= 0) void'(q[acc_src].pop_front());
    for (int i = 0; i < N; i++) begin
      src_valid[i] = en[i] && (q[i].size() > 0);
      src_bits[i*W +: W] = (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
    serial_out_ready = rdy;
    #1;
    sample();
  endtask

  initial begin
    int total, guard, gap[N];

    // Reset state
    do_reset();
    check("rst_valid", 32'(serial_out_valid), 32'd0);
    check("rst_bits", 32'(serial_out_bits), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_idx), 32'd0);
    check("rst_ready", 32'(src_ready), 32'd0);

    // 1: src1 sends "hi\n"
    load(1, "hi\n");
    cycle(); check("t1_c1_busy", 32'(busy), 32'd0); check("t1_c1_ov", 32'(serial_out_valid), 32'd0);
    cycle(); check("t1_c2_busy", 32'(busy), 32'd1); check("t1_c2_grant", 32'(grant_idx), 32'd1);
             check("t1_c2_ready", 32'(src_ready), 32'b0010);
    cycle(); check("t1_c3_ov", 32'(serial_out_valid), 32'd1); check("t1_c3_bits", 32'(serial_out_bits), 32'h68);
    cycle(); check("t1_c4_bits", 32'(serial_out_bits), 32'h69);
    cycle(); check("t1_c5_bits", 32'(serial_out_bits), 32'h0A); check("t1_c5_busy", 32'(busy), 32'd0);
    // rr_ptr is now 2: with src0 and src2 both requesting, src2 wins
    load(0, "b\n"); load(2, "c\n");
    cycle();
    cycle(); check("t1_rr2_grant", 32'(grant_idx), 32'd2);
    repeat (10) cycle();
    check_log("t1", "hi\nc\nb\n");

    // 2: src0 and src2 from reset, no interleaving
    do_reset();
    load(0, "a\n"); load(2, "a\n");
    repeat (12) cycle();
    check_log("t2", "a\na\n");
    check("t2_seg0_src", 32'(seg_src_log[0]), 32'd0);
    check("t2_seg1_src", 32'(seg_src_log[1]), 32'd2);

    // 3: src3 streams 70 bytes without EOL
    do_reset();
    for (int i = 0; i < 70; i++) q[3].push_back(8'(8'h20 + i));
    repeat (120) cycle();
    check("t3_segs", 32'(seg_len_log.size()), 32'd2);
    check("t3_seg0_len", 32'(seg_len_log[0]), 32'd64);
    check("t3_seg0_src", 32'(seg_src_log[0]), 32'd3);
    check("t3_seg1_len", 32'(seg_len_log[1]), 32'd6);
    check("t3_seg1_src", 32'(seg_src_log[1]), 32'd3);
    check("t3_bytes", 32'(out_log.size()), 32'd70);

    // 4: idle timeout releases src0, then src1 is granted
    do_reset();
    q[0].push_back(8'h41);
    load(1, "B\n");
    cycle(); cycle();
    check("t4_grant0", 32'(grant_idx), 32'd0);
    repeat (16) cycle();
    check("t4_c18_busy", 32'(busy), 32'd1);
    cycle(); check("t4_c19_busy", 32'(busy), 32'd0);
    cycle(); check("t4_c20_busy", 32'(busy), 32'd1); check("t4_c20_grant", 32'(grant_idx), 32'd1);
    repeat (6) cycle();
    check_log("t4", "AB\n");

    // 5: UART stall mid-line
    do_reset();
    load(2, "abcde\n");
    cycle(); cycle(); cycle();
    rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("t5_ov", 32'(serial_out_valid), 32'd1);
      check("t5_bits", 32'(serial_out_bits), 32'h62);
      check("t5_ready", 32'(src_ready), 32'd0);
    end
    rdy = 1'b1;
    repeat (12) cycle();
    check_log("t5", "abcde\n");

    // 6: async reset mid-line, then round-robin restarts at 0 (rr was 3)
    load(1, "xyz\n");
    cycle(); cycle(); cycle();
    check("t6_pre_ov", 32'(serial_out_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_ov", 32'(serial_out_valid), 32'd0);
    check("t6_rst_bits", 32'(serial_out_bits), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_grant", 32'(grant_idx), 32'd0);
    check("t6_rst_ready", 32'(src_ready), 32'd0);
    do_reset();
    load(3, "q\n"); load(0, "p\n");
    cycle(); cycle();
    check("t6_grant0", 32'(grant_idx), 32'd0);
    repeat (8) cycle();
    check_log("t6", "p\nq\n");

    // Random phase
    do_reset();
    total = 0;
    for (int s = 0; s < N; s++) begin
      gap[s] = 0;
      for (int l = 0; l < int'($urandom_range(2, 5)); l++) begin
        for (int c = 0; c < int'($urandom_range(1, 90)); c++) q[s].push_back(8'($urandom_range(32, 126)));
        if ($urandom_range(0, 3) != 0) q[s].push_back(8'h0A);
      end
      total += q[s].size();
    end
    for (int t = 0; t < 2500; t++) begin
      for (int s = 0; s < N; s++) begin
        if (gap[s] > 0) begin
          gap[s]--;
          en[s] = 1'b0;
        end else begin
          if ($urandom_range(0, 149) == 0) gap[s] = int'($urandom_range(10, 30));
          en[s] = ($urandom_range(0, 7) != 0);
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end
    for (int s = 0; s < N; s++) en[s] = 1'b1;
    rdy = 1'b1;
    guard = 0;
    while ((pending() || exp_out.size() > 0 || serial_out_valid) && guard < 3000) begin
      cycle();
      guard++;
    end
    check("rand_drain", 32'(guard < 3000), 32'd1);
    check("rand_total", 32'(out_log.size()), 32'(total));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
